uart_tx_arbiter: RTL and testbench

- Shares a single UART transmitter between NUM_REQ byte producers, e.g. the program loader echo path, the debug/status reporter and the core's MMIO console.
- Round-robin arbitration selects one requester at a time.
- Drives the transmitter's start/data inputs and holds start until the transmitter acknowledges via busy.
- Releases the transmitter only after the full frame (start, 8 data, stop) has gone out.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to abandon a launch when busy never rises within TIMEOUT_CYCLES.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 active,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  state_t         state, state_nx;
  logic [IDW-1:0] ptr, ptr_nx, ptr_adv, grant_nx, sel;
  logic [7:0]     data_nx, sel_byte;
  logic           start_nx, active_nx, found, grant;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt, tmo_cnt_nx;
  logic          err_nx;
`endif

  // Rotating priority as two passes: first valid at or above ptr, else first valid from 0.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_byte = '0;
    for (int unsigned g = 0; g < NUM_REQ; g++) begin
      if (!found && req_valid[g] && (g >= 32'(ptr))) begin
        found    = 1'b1;
        sel      = IDW'(g);
        sel_byte = req_data[8*g +: 8];
      end
    end
    for (int unsigned g = 0; g < NUM_REQ; g++) begin
      if (!found && req_valid[g]) begin
        found    = 1'b1;
        sel      = IDW'(g);
        sel_byte = req_data[8*g +: 8];
      end
    end
  end

  assign grant   = (state == IDLE) && !uart_tx_busy && found;
  assign ptr_adv = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    for (int unsigned g = 0; g < NUM_REQ; g++) begin
      req_ready[g] = grant && (sel == IDW'(g));
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    grant_nx  = grant_id;
    start_nx  = uart_tx_start;
    active_nx = active;
    data_nx   = uart_tx_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
    tmo_cnt_nx = tmo_cnt;
    err_nx     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (grant) begin
          state_nx  = LAUNCH;
          data_nx   = sel_byte;
          grant_nx  = sel;
          active_nx = 1'b1;
          start_nx  = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
          tmo_cnt_nx = '0;
`endif
        end
      end
      LAUNCH: begin
        if (uart_tx_busy) begin
          start_nx = 1'b0;
          state_nx = WAIT;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          start_nx  = 1'b0;
          active_nx = 1'b0;
          err_nx    = 1'b1;
          ptr_nx    = ptr_adv;
          state_nx  = IDLE;
        end else begin
          tmo_cnt_nx = tmo_cnt + 1'b1;
        end
`endif
      end
      WAIT: begin
        if (!uart_tx_busy) begin
          active_nx = 1'b0;
          ptr_nx    = ptr_adv;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_id      <= '0;
      active        <= 1'b0;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else begin
      state         <= state_nx;
      ptr           <= ptr_nx;
      grant_id      <= grant_nx;
      active        <= active_nx;
      uart_tx_start <= start_nx;
      uart_tx_data  <= data_nx;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt     <= tmo_cnt_nx;
      timeout_err <= err_nx;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a transmitter model records launched frames and each test
// compares them against the frames it expects, plus inline timing checks.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           start0, active0, terr0;
  logic [7:0]     data0;
  logic [1:0]     gid0;

  logic [0:0] valid1 = '0;
  logic [0:0] ready1, gid1;
  logic [7:0] rdata1 = '0;
  logic [7:0] data1;
  logic       start1, active1, terr1;

  logic uart_busy;
  logic busy_m = 1'b0;
  logic force_busy = 1'b0;
  logic xmit_en = 1'b1;
  logic use_d1 = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int start_rises = 0;
  int dly_cfg = 3;
  int frame_cfg = 5;
  int mst = 0;
  int mcnt = 0;

  logic [11:0] exp_q[$];
  logic [11:0] act_q[$];

  assign uart_busy = busy_m | force_busy;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .uart_tx_start(start0), .uart_tx_data(data0),
    .uart_tx_busy(uart_busy), .grant_id(gid0), .active(active0), .timeout_err(terr0)
  );

  uart_tx_arbiter #(.NUM_REQ(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_data(rdata1),
    .req_ready(ready1), .uart_tx_start(start1), .uart_tx_data(data1),
    .uart_tx_busy(uart_busy), .grant_id(gid1), .active(active1), .timeout_err(terr1)
  );

  logic       m_start;
  logic [7:0] m_data;
  logic [3:0] m_id;
  assign m_start = use_d1 ? start1 : start0;
  assign m_data  = use_d1 ? data1 : data0;
  assign m_id    = use_d1 ? 4'd0 : {2'b00, gid0};

  always @(posedge m_start) start_rises++;

  // Transmitter model: busy rises dly_cfg cycles after start is first seen, lasts frame_cfg cycles.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      busy_m = 1'b0;
      mst = 0;
      mcnt = 0;
    end else begin
      case (mst)
        0: if (xmit_en && m_start) begin mst = 1; mcnt = 1; end
        1: if (mcnt == dly_cfg - 1) begin
             busy_m = 1'b1;
             act_q.push_back({m_id, m_data});
             mst = 2;
             mcnt = 0;
           end else mcnt++;
        default: if (mcnt == frame_cfg - 1) begin
             busy_m = 1'b0;
             mst = 0;
           end else mcnt++;
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (start0 !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start0); end
    n_checks++; if (data0 !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data0); end
    n_checks++; if (gid0 !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", gid0); end
    n_checks++; if (active0 !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active0); end
    n_checks++; if (terr0 !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b want 0", terr0); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    int cnt;
    logic [11:0] e, a;
    dly_cfg = 27;
    frame_cfg = 10;
    tick();
    req_data = {8'h43, 8'h32, 8'hA5, 8'h10};
    req_valid = 4'b0010;
    exp_q.push_back({4'd1, 8'hA5});
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL t1_ready: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    req_data = '0;
    n_checks++; if (gid0 !== 2'd1) begin n_fail++; $display("FAIL t1_grant: got %0d want 1", gid0); end
    cnt = 0;
    while (start0 === 1'b1 && cnt < 200) begin cnt++; tick(); end
    n_checks++; if (cnt != 27) begin n_fail++; $display("FAIL t1_start_len: got %0d want 27", cnt); end
    n_checks++; if (data0 !== 8'hA5) begin n_fail++; $display("FAIL t1_data_hold: got %h want a5", data0); end
    cnt = 0;
    while (uart_busy === 1'b1 && cnt < 100) begin cnt++; tick(); end
    n_checks++; if (active0 !== 1'b1) begin n_fail++; $display("FAIL t1_active_hold: got %b want 1", active0); end
    n_checks++; if (data0 !== 8'hA5) begin n_fail++; $display("FAIL t1_data_busyfall: got %h want a5", data0); end
    tick();
    n_checks++; if (active0 !== 1'b0) begin n_fail++; $display("FAIL t1_active_fall: got %b want 0", active0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL t1_frame: got none want %h", e); end
      else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL t1_frame: got %h want %h", a, e); end end
    end
  endtask

  task automatic test_round_robin();
    int cyc, bad;
    logic [11:0] e, a;
    do_reset();
    act_q.delete();
    dly_cfg = 3;
    frame_cfg = 5;
    start_rises = 0;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = 4'b1111;
    exp_q.push_back(12'h010); exp_q.push_back(12'h121); exp_q.push_back(12'h232);
    exp_q.push_back(12'h343); exp_q.push_back(12'h010);
    bad = 0;
    cyc = 0;
    while (act_q.size() < 5 && cyc < 1000) begin
      tick();
      cyc++;
      if (active0 === 1'b1 && req_ready !== 4'b0000) bad++;
    end
    req_valid = '0;
    cyc = 0;
    while (active0 === 1'b1 && cyc < 100) begin tick(); cyc++; end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t2_ready_while_active: got %0d cycles want 0", bad); end
    n_checks++; if (start_rises != 5) begin n_fail++; $display("FAIL t2_start_count: got %0d want 5", start_rises); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL t2_frame: got none want %h", e); end
      else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL t2_frame: got %h want %h", a, e); end end
    end
  endtask

  task automatic test_busy_at_reset();
    int cyc;
    logic [11:0] e, a;
    tick();
    reset = 1'b1;
    force_busy = 1'b1;
    req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
    req_valid = 4'b0001;
    tick();
    reset = 1'b0;
    repeat (5) begin
      tick();
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL t3_no_ready: got %b want 0000", req_ready); end
    end
    force_busy = 1'b0;
    exp_q.push_back({4'd0, 8'h5A});
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t3_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_checks++; if (start0 !== 1'b1 || gid0 !== 2'd0) begin n_fail++; $display("FAIL t3_grant: got start=%b id=%0d want start=1 id=0", start0, gid0); end
    cyc = 0;
    while (active0 === 1'b1 && cyc < 200) begin tick(); cyc++; end
    n_checks++; if (active0 !== 1'b0) begin n_fail++; $display("FAIL t3_release: got %b want 0", active0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL t3_frame: got none want %h", e); end
      else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL t3_frame: got %h want %h", a, e); end end
    end
  endtask

  task automatic test_reset_wait();
    int cyc;
    logic [11:0] e, a;
    tick();
    req_data = {8'h00, 8'h77, 8'hC3, 8'h0F};
    req_valid = 4'b0010;
    exp_q.push_back({4'd1, 8'hC3});
    tick();
    req_valid = '0;
    cyc = 0;
    while (uart_busy !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    tick();
    n_checks++; if (start0 !== 1'b0 || active0 !== 1'b1) begin n_fail++; $display("FAIL t4_in_wait: got start=%b active=%b want 0 1", start0, active0); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (active0 !== 1'b0) begin n_fail++; $display("FAIL t4_async_active: got %b want 0", active0); end
    n_checks++; if (data0 !== 8'h00) begin n_fail++; $display("FAIL t4_async_data: got %h want 00", data0); end
    n_checks++; if (gid0 !== 2'd0) begin n_fail++; $display("FAIL t4_async_grant: got %0d want 0", gid0); end
    tick();
    reset = 1'b0;
    req_valid = 4'b0101;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t4_ptr_cleared: got %b want 0001", req_ready); end
    req_valid = 4'b0100;
    exp_q.push_back({4'd2, 8'h77});
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL t4_ready2: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    n_checks++; if (gid0 !== 2'd2) begin n_fail++; $display("FAIL t4_grant2: got %0d want 2", gid0); end
    cyc = 0;
    while (active0 === 1'b1 && cyc < 200) begin tick(); cyc++; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL t4_frame: got none want %h", e); end
      else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL t4_frame: got %h want %h", a, e); end end
    end
  endtask

  task automatic test_timeout();
    int cnt, terr_seen;
    xmit_en = 1'b0;
    tick();
    req_data = {8'hEE, 8'h00, 8'h00, 8'h3C};
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    cnt = 0;
    terr_seen = 0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    while (start0 === 1'b1 && cnt < 100) begin
      if (terr0 === 1'b1) terr_seen++;
      cnt++;
      tick();
    end
    n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL t5_start_len: got %0d want 16", cnt); end
    n_checks++; if (terr0 !== 1'b1 || active0 !== 1'b0) begin n_fail++; $display("FAIL t5_expire: got err=%b active=%b want 1 0", terr0, active0); end
    tick();
    n_checks++; if (terr0 !== 1'b0 || terr_seen != 0) begin n_fail++; $display("FAIL t5_pulse_width: got err=%b early=%0d want 0 0", terr0, terr_seen); end
    xmit_en = 1'b1;
    req_valid = 4'b1001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL t5_next_grant: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    cnt = 0;
    while (active0 === 1'b1 && cnt < 200) begin tick(); cnt++; end
    act_q.delete();
`else
    while (start0 === 1'b1 && cnt < 40) begin
      if (terr0 !== 1'b0) terr_seen++;
      cnt++;
      tick();
    end
    n_checks++; if (cnt != 40) begin n_fail++; $display("FAIL t5_start_held: got %0d want 40", cnt); end
    n_checks++; if (terr_seen != 0) begin n_fail++; $display("FAIL t5_no_err: got %0d want 0", terr_seen); end
    do_reset();
    xmit_en = 1'b1;
`endif
  endtask

  task automatic test_single_req();
    int cyc;
    logic [11:0] e, a;
    act_q.delete();
    use_d1 = 1'b1;
    start_rises = 0;
    tick();
    rdata1 = 8'h55;
    valid1 = 1'b1;
    exp_q.push_back({4'd0, 8'h55});
    #1;
    n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL t6_ready: got %b want 1", ready1); end
    tick();
    rdata1 = 8'hAA;
    exp_q.push_back({4'd0, 8'hAA});
    cyc = 0;
    while (act_q.size() < 2 && cyc < 500) begin tick(); cyc++; end
    valid1 = 1'b0;
    cyc = 0;
    while (active1 === 1'b1 && cyc < 200) begin tick(); cyc++; end
    n_checks++; if (start_rises != 2) begin n_fail++; $display("FAIL t6_start_count: got %0d want 2", start_rises); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL t6_frame: got none want %h", e); end
      else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL t6_frame: got %h want %h", a, e); end end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_at_reset();
    test_reset_wait();
    test_timeout();
    test_single_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
